// File: rtl/fan_pkg.sv
// Shared fan-display definitions: angle range, LED word width, scheduler state encoding.
package fan_pkg;
  localparam int unsigned DEG_MAX = 360;
  localparam int unsigned DEG_W   = 9;
  localparam int unsigned LED_W   = 16;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned REV_W   = 8;
  localparam int unsigned BLANK_W = 4;

  typedef enum logic {
    RUN   = 1'b0,
    BLANK = 1'b1
  } fan_state_t;
endpackage

// File: rtl/pattern_scheduler_if.sv
// Pattern scheduler bus: fan angle strobe, user controls, generator LED words and display outputs.
//   master: drives fanclk, next_btn, auto_en, pat_led_in; receives deg, pat_sel, led, rev_done
//   slave : the scheduler side of the same signals
interface pattern_scheduler_if #(
  parameter int unsigned NUM_PAT = 4
);
  import fan_pkg::*;

  logic                       fanclk;
  logic                       next_btn;
  logic                       auto_en;
  logic [NUM_PAT*LED_W-1:0]   pat_led_in;
  logic [DEG_W-1:0]           deg;
  logic [SEL_W-1:0]           pat_sel;
  logic [LED_W-1:0]           led;
  logic                       rev_done;

  modport master (
    output fanclk, next_btn, auto_en, pat_led_in,
    input  deg, pat_sel, led, rev_done
  );

  modport slave (
    input  fanclk, next_btn, auto_en, pat_led_in,
    output deg, pat_sel, led, rev_done
  );
endinterface

// File: rtl/fan_angle_counter.sv
// Blade angle counter: counts DEG_MAX..1 on each fanclk cycle and flags revolution wraps.
//   clk, rst : clock, synchronous active-high reset
//   fanclk   : degree-step qualifier
//   deg      : current angle (registered, 1..DEG_MAX)
//   wrap_c   : combinational, high in the cycle whose edge reloads DEG_MAX
//   rev_done : registered, high in the first cycle at DEG_MAX after a wrap
module fan_angle_counter
  import fan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             fanclk,
  output logic [DEG_W-1:0] deg,
  output logic             wrap_c,
  output logic             rev_done
);

  assign wrap_c = fanclk && (deg == DEG_W'(1));

  // Angle register and revolution pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      deg      <= DEG_W'(DEG_MAX);
      rev_done <= 1'b0;
    end else begin
      rev_done <= wrap_c;
      if (wrap_c) begin
        deg <= DEG_W'(DEG_MAX);
      end else if (fanclk) begin
        deg <= deg - DEG_W'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_scheduler.sv
// Selects which external pattern generator drives the blade LEDs, switching only at
// revolution wraps (manual button or auto timer) with blank revolutions between patterns.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pattern_scheduler_if (fanclk, next_btn, auto_en, pat_led_in in;
//              deg, pat_sel, led, rev_done out)
module pattern_scheduler
  import fan_pkg::*;
#(
  parameter int unsigned NUM_PAT     = 4,
  parameter int unsigned REV_PER_PAT = 64,
  parameter int unsigned BLANK_REVS  = 1
) (
  input  logic                clk,
  input  logic                rst,
  pattern_scheduler_if.slave  bus
);

  logic [DEG_W-1:0]   deg;
  logic               wrap_c;
  logic               rev_done;

  fan_state_t         state_q, state_d;
  logic [SEL_W-1:0]   pat_sel_q, pat_sel_d;
  logic               pending_q, pending_d;
  logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;
  logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [LED_W-1:0]   led_sel_c;

  fan_angle_counter u_angle (
    .clk      (clk),
    .rst      (rst),
    .fanclk   (bus.fanclk),
    .deg      (deg),
    .wrap_c   (wrap_c),
    .rev_done (rev_done)
  );

  assign bus.deg      = deg;
  assign bus.rev_done = rev_done;
  assign bus.pat_sel  = pat_sel_q;
  assign bus.led      = led_q;

  // LED word of the active pattern
  always_comb begin
    led_sel_c = '0;
    for (int unsigned k = 0; k < NUM_PAT; k++) begin
      if (pat_sel_q == SEL_W'(k)) begin
        led_sel_c = bus.pat_led_in[k*LED_W +: LED_W];
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pat_sel_q   <= '0;
      pending_q   <= 1'b0;
      rev_cnt_q   <= '0;
      blank_cnt_q <= '0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      pat_sel_q   <= pat_sel_d;
      pending_q   <= pending_d;
      rev_cnt_q   <= rev_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      led_q       <= led_d;
    end
  end

  // Next-state: a press coinciding with the wrap counts as pending for that wrap,
  // and a manual/auto coincidence still advances pat_sel only once.
  always_comb begin
    state_d     = state_q;
    pat_sel_d   = pat_sel_q;
    pending_d   = pending_q;
    rev_cnt_d   = rev_cnt_q;
    blank_cnt_d = blank_cnt_q;
    led_d       = '0;

    case (state_q)
      RUN: begin
        led_d = led_sel_c;
        if (wrap_c) begin
          if (pending_q || bus.next_btn ||
              (bus.auto_en && (rev_cnt_q == REV_W'(REV_PER_PAT - 1)))) begin
            pat_sel_d   = (pat_sel_q == SEL_W'(NUM_PAT - 1)) ? '0 : pat_sel_q + SEL_W'(1);
            pending_d   = 1'b0;
            rev_cnt_d   = '0;
            blank_cnt_d = '0;
            state_d     = BLANK;
          end else if (bus.auto_en) begin
            rev_cnt_d = rev_cnt_q + REV_W'(1);
          end
        end else if (bus.next_btn) begin
          pending_d = 1'b1;
        end
      end
      BLANK: begin
        if (wrap_c) begin
          if (blank_cnt_q == BLANK_W'(BLANK_REVS - 1)) begin
            blank_cnt_d = '0;
            state_d     = RUN;
          end else begin
            blank_cnt_d = blank_cnt_q + BLANK_W'(1);
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_pattern_scheduler.sv
module tb_pattern_scheduler;
  logic clk;
  logic rst;
  logic [15:0] pat0;
  int passed;
  int total;
  int m_deg;

  pattern_scheduler_if #(.NUM_PAT(4)) bus ();

  pattern_scheduler #(
    .NUM_PAT     (4),
    .REV_PER_PAT (2),
    .BLANK_REVS  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.pat_led_in = {16'h4444, 16'h3333, 16'h2222, pat0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fan;
    logic        btn;
    logic [15:0] pat0;
    logic [8:0]  edeg;
    logic [15:0] eled;
    logic [2:0]  esel;
    logic        erd;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input logic fan, input logic btn);
    bus.fanclk   = fan;
    bus.next_btn = btn;
    @(posedge clk);
    #1;
    if (fan) m_deg = (m_deg == 1) ? 360 : m_deg - 1;
    bus.fanclk   = 1'b0;
    bus.next_btn = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.fanclk   = 1'b1;
    bus.next_btn = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.fanclk   = 1'b0;
    bus.next_btn = 1'b0;
    m_deg        = 360;
  endtask

  // Step up to and including the next wrap edge
  task automatic to_wrap();
    while (m_deg != 1) tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  task automatic run_to(input int d);
    while (m_deg != d) tick(1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int rd_cnt;
    int rd_pos;
    passed       = 0;
    total        = 0;
    rst          = 1'b1;
    pat0         = 16'h1111;
    bus.fanclk   = 1'b0;
    bus.next_btn = 1'b0;
    bus.auto_en  = 1'b0;
    m_deg        = 360;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 16'h0AAA, 9'd360, 16'h0000, 3'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0AAA, 9'd359, 16'h0AAA, 3'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 16'h0BBB, 9'd359, 16'h0BBB, 3'd0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0CCC, 9'd358, 16'h0CCC, 3'd0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0CCC, 9'd357, 16'h0CCC, 3'd0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0DDD, 9'd360, 16'h0000, 3'd0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 16'h1111, 9'd360, 16'h1111, 3'd0, 1'b0};

    do_reset();
    check("reset_deg", int'(bus.deg), 360);
    check("reset_led", int'(bus.led), 0);
    check("reset_sel", int'(bus.pat_sel), 0);
    check("reset_rd", int'(bus.rev_done), 0);

    // Single-cycle vectors: reset override, step, hold, one-cycle LED latency
    for (int i = 0; i < 7; i++) begin
      rst          = vecs[i].rst;
      bus.fanclk   = vecs[i].fan;
      bus.next_btn = vecs[i].btn;
      pat0         = vecs[i].pat0;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_deg", i), int'(bus.deg), int'(vecs[i].edeg));
      check($sformatf("tbl%0d_led", i), int'(bus.led), int'(vecs[i].eled));
      check($sformatf("tbl%0d_sel", i), int'(bus.pat_sel), int'(vecs[i].esel));
      check($sformatf("tbl%0d_rd", i), int'(bus.rev_done), int'(vecs[i].erd));
    end
    rst          = 1'b0;
    bus.fanclk   = 1'b0;
    bus.next_btn = 1'b0;
    m_deg        = 360;

    // Full revolution sweep
    bad = 0; rd_cnt = 0; rd_pos = -1;
    for (int i = 1; i <= 361; i++) begin
      tick(i <= 360, 1'b0);
      if (int'(bus.deg) != m_deg) bad++;
      if (bus.led != 16'h1111) bad++;
      if (bus.rev_done) begin rd_cnt++; rd_pos = i; end
    end
    check("sweep_deg_led_errors", bad, 0);
    check("sweep_rev_done_count", rd_cnt, 1);
    check("sweep_rev_done_pos", rd_pos, 360);
    check("sweep_sel", int'(bus.pat_sel), 0);

    // fanclk idle for 1000 cycles
    bad = 0; rd_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1'b0, 1'b0);
      if (bus.deg != 9'd360 || bus.led != 16'h1111 || bus.pat_sel != 3'd0) bad++;
      if (bus.rev_done) rd_cnt++;
    end
    check("idle_stable_errors", bad, 0);
    check("idle_rev_done", rd_cnt, 0);

    // Manual: two presses in one revolution give one switch
    run_to(200);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    run_to(1);
    check("man_sel_prewrap", int'(bus.pat_sel), 0);
    tick(1'b1, 1'b0);
    check("man_sel_wrap", int'(bus.pat_sel), 1);
    check("man_deg_wrap", int'(bus.deg), 360);
    check("man_rd_wrap", int'(bus.rev_done), 1);
    check("man_led_last_run", int'(bus.led), 16'h1111);
    tick(1'b1, 1'b1);
    check("man_led_blank", int'(bus.led), 0);
    bad = 0;
    while (m_deg != 1) begin
      tick(1'b1, 1'b0);
      if (bus.led != 16'h0000) bad++;
    end
    check("man_blank_errors", bad, 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("man_led_pat1", int'(bus.led), 16'h2222);
    to_wrap();
    check("man_second_press_dropped", int'(bus.pat_sel), 1);

    // Auto mode, REV_PER_PAT=2
    do_reset();
    bus.auto_en = 1'b1;
    to_wrap();
    check("auto_wrap1_sel", int'(bus.pat_sel), 0);
    to_wrap();
    check("auto_wrap2_sel", int'(bus.pat_sel), 1);
    tick(1'b1, 1'b0);
    check("auto_blank_led", int'(bus.led), 0);
    run_to(1);
    check("auto_blank_led_end", int'(bus.led), 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("auto_wrap3_led", int'(bus.led), 16'h2222);
    to_wrap();
    check("auto_wrap4_sel", int'(bus.pat_sel), 1);
    // pending and auto condition coincide: advance by one only
    run_to(100);
    tick(1'b1, 1'b1);
    to_wrap();
    check("coincide_sel", int'(bus.pat_sel), 2);
    to_wrap();

    // Press in the wrap cycle counts for that wrap
    bus.auto_en = 1'b0;
    run_to(1);
    tick(1'b1, 1'b1);
    check("btn_at_wrap_sel", int'(bus.pat_sel), 3);
    to_wrap();
    // Index wraps NUM_PAT-1 -> 0
    tick(1'b1, 1'b1);
    to_wrap();
    check("sel_wrap_to_0", int'(bus.pat_sel), 0);
    to_wrap();

    // Reset in BLANK aborts the switch sequence
    tick(1'b1, 1'b1);
    to_wrap();
    check("pre_rst_sel", int'(bus.pat_sel), 1);
    tick(1'b1, 1'b1);
    run_to(50);
    do_reset();
    check("rst_blank_deg", int'(bus.deg), 360);
    check("rst_blank_sel", int'(bus.pat_sel), 0);
    check("rst_blank_led", int'(bus.led), 0);
    tick(1'b1, 1'b0);
    check("rst_blank_run_led", int'(bus.led), 16'h1111);
    to_wrap();
    check("rst_blank_no_switch", int'(bus.pat_sel), 0);

    // Reset mid-revolution with pending set
    run_to(180);
    tick(1'b1, 1'b1);
    do_reset();
    to_wrap();
    check("rst_pend_no_switch", int'(bus.pat_sel), 0);
    tick(1'b1, 1'b0);
    check("rst_pend_still_run", int'(bus.led), 16'h1111);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
